// File: rtl/led_blink_multi.sv
// led_blink_multi: CHANNELS independent LEDs (OFF/ON/BLINK/PULSE) programmed through a one-cycle write port; define LED_PWM_EN to add global PWM brightness
module led_blink_multi #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 24,
    parameter int CH_W     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [CNT_W-1:0]    cfg_period,
`ifdef LED_PWM_EN
    input  logic [7:0]          bright,
`endif
    output logic [CHANNELS-1:0] led,
    output logic [CHANNELS-1:0] busy
);
    localparam logic [1:0] M_OFF   = 2'd0;
    localparam logic [1:0] M_ON    = 2'd1;
    localparam logic [1:0] M_BLINK = 2'd2;
    localparam logic [1:0] M_PULSE = 2'd3;

    logic [CHANNELS-1:0] lit;
    logic [CHANNELS-1:0] act;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [1:0]       mode_q, mode_d;
        logic [CNT_W-1:0] period_q, period_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             led_q, led_d;
        logic             busy_q, busy_d;
        logic             sel, tc;

        // Out-of-range channel indices never match any channel, so such writes are dropped
        assign sel = cfg_we && (int'(cfg_ch) == g);
        assign tc  = cnt_q == period_q;

        // Channel state register; a write always beats the terminal count
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mode_q   <= M_OFF;
                period_q <= '0;
                cnt_q    <= '0;
                led_q    <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                mode_q   <= mode_d;
                period_q <= period_d;
                cnt_q    <= cnt_d;
                led_q    <= led_d;
                busy_q   <= busy_d;
            end
        end

        // Next state: load on write, PULSE falls back to OFF after its window, counter runs only in BLINK/PULSE
        always_comb begin
            mode_d   = sel ? cfg_mode : (mode_q == M_PULSE && tc) ? M_OFF : mode_q;
            period_d = sel ? cfg_period : period_q;
            cnt_d    = (sel || tc || !mode_q[1]) ? '0 : cnt_q + CNT_W'(1);
        end

        // Outputs: any non-OFF mode lights on entry; BLINK toggles at terminal count, PULSE drops at it
        always_comb begin
            led_d  = sel ? (cfg_mode != M_OFF)
                   : (mode_q == M_BLINK) ? (led_q ^ tc)
                   : (mode_q == M_PULSE) ? !tc
                   : (mode_q == M_ON);
            busy_d = sel ? (cfg_mode == M_PULSE) : (mode_q == M_PULSE) && !tc;
        end

        assign lit[g] = led_q;
        assign act[g] = busy_q;
    end

    assign busy = act;

`ifdef LED_PWM_EN
    logic [7:0]          pwm_cnt_q, pwm_cnt_d;
    logic [CHANNELS-1:0] pwm_led_q, pwm_led_d;

    // PWM counter and gated LED register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q <= '0;
            pwm_led_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            pwm_led_q <= pwm_led_d;
        end
    end

    // Free-running 8-bit ramp compared against the global brightness
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        pwm_led_d = lit & {CHANNELS{pwm_cnt_q < bright}};
    end

    assign led = pwm_led_q;
`else
    assign led = lit;
`endif
endmodule

// File: tb/tb_led_blink_multi.sv
// tb_led_blink_multi: directed self-checking bench for led_blink_multi
module tb_led_blink_multi;
    localparam int CHANNELS = 4;
    localparam int CNT_W    = 8;
    localparam int CH_W     = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cfg_we = 1'b0;
    logic [CH_W-1:0]     cfg_ch = '0;
    logic [1:0]          cfg_mode = '0;
    logic [CNT_W-1:0]    cfg_period = '0;
`ifdef LED_PWM_EN
    logic [7:0]          bright = 8'd0;
    int                  hi;
`endif
    logic [CHANNELS-1:0] led, busy;
    logic [CHANNELS-1:0] e;
    int                  ncmp = 0;
    int                  nfail = 0;

    led_blink_multi #(.CHANNELS(CHANNELS), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
        .clk(clk),
        .rst(rst),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode),
        .cfg_period(cfg_period),
`ifdef LED_PWM_EN
        .bright(bright),
`endif
        .led(led),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [CHANNELS-1:0] obs, input logic [CHANNELS-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

`ifdef LED_PWM_EN
    task automatic chkn(input string tag, input int obs, input int exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
`endif

    task automatic wr(input int ch, input int mode, input int p);
        cfg_we = 1'b1;
        cfg_ch = CH_W'(ch);
        cfg_mode = 2'(mode);
        cfg_period = CNT_W'(p);
        tick;
        cfg_we = 1'b0;
    endtask

    initial begin
        cfg_we = 1'b1;
        cfg_ch = '0;
        cfg_mode = 2'd1;
        repeat (3) begin
            tick;
            chk("rst_led", led, 4'b0000);
            chk("rst_busy", busy, 4'b0000);
        end
        cfg_we = 1'b0;
        rst = 1'b0;
        tick;
        chk("post_rst_led", led, 4'b0000);
        chk("post_rst_busy", busy, 4'b0000);
`ifndef LED_PWM_EN
        wr(0, 2, 4);
        for (int k = 0; k < 20; k++) begin
            chk("blink_p4_led", led, ((k / 5) % 2 == 0) ? 4'b0001 : 4'b0000);
            chk("blink_p4_busy", busy, 4'b0000);
            tick;
        end
        wr(0, 0, 0);
        chk("off_led", led, 4'b0000);
        wr(2, 3, 9);
        for (int k = 0; k < 12; k++) begin
            e = (k < 10) ? 4'b0100 : 4'b0000;
            chk("pulse_led", led, e);
            chk("pulse_busy", busy, e);
            tick;
        end
        wr(2, 3, 9);
        for (int k = 0; k < 5; k++) begin
            chk("pulse_pre_led", led, 4'b0100);
            tick;
        end
        wr(2, 3, 9);
        for (int k = 0; k < 12; k++) begin
            e = (k < 10) ? 4'b0100 : 4'b0000;
            chk("pulse_rw_led", led, e);
            chk("pulse_rw_busy", busy, e);
            tick;
        end
        wr(1, 2, 0);
        for (int k = 0; k < 8; k++) begin
            chk("blink_p0_led", led, (k % 2 == 0) ? 4'b0010 : 4'b0000);
            tick;
        end
        wr(1, 0, 0);
        wr(0, 1, 0);
        chk("on_led", led, 4'b0001);
        wr(5, 0, 0);
        chk("badch_off_led", led, 4'b0001);
        wr(5, 3, 3);
        chk("badch_pulse_led", led, 4'b0001);
        chk("badch_pulse_busy", busy, 4'b0000);
        wr(7, 2, 1);
        tick;
        chk("badch_blink_led", led, 4'b0001);
        wr(0, 0, 0);
        wr(3, 1, 0);
        wr(1, 3, 3);
        wr(0, 2, 2);
        for (int k = 0; k < 12; k++) begin
            e = 4'b1000 | (((k / 3) % 2 == 0) ? 4'b0001 : 4'b0000) | ((k + 1 < 4) ? 4'b0010 : 4'b0000);
            chk("multi_led", led, e);
            chk("multi_busy", busy, (k + 1 < 4) ? 4'b0010 : 4'b0000);
            if (k < 11) tick;
        end
        wr(0, 0, 0);
        chk("prec_led", led, 4'b1000);
        repeat (3) begin
            tick;
            chk("prec_hold_led", led, 4'b1000);
        end
`else
        wr(0, 1, 0);
`endif
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_led", led, 4'b0000);
        chk("async_rst_busy", busy, 4'b0000);
        tick;
        rst = 1'b0;
        repeat (4) begin
            tick;
            chk("no_resume_led", led, 4'b0000);
            chk("no_resume_busy", busy, 4'b0000);
        end
`ifdef LED_PWM_EN
        wr(0, 1, 0);
        bright = 8'd64;
        tick;
        tick;
        hi = 0;
        repeat (256) begin
            tick;
            hi += int'(led[0]);
        end
        chkn("pwm64_high", hi, 64);
        bright = 8'd0;
        tick;
        tick;
        hi = 0;
        repeat (256) begin
            tick;
            hi += int'(led[0]);
        end
        chkn("pwm0_high", hi, 0);
        bright = 8'd255;
        tick;
        tick;
        hi = 0;
        repeat (256) begin
            tick;
            hi += int'(led[0]);
        end
        chkn("pwm255_high", hi, 255);
        chk("pwm_busy", busy, 4'b0000);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
